fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register of the 5-stage MIPS core: owns the PC, picks the next PC and drives a synchronous instruction ROM.
//  Sits directly upstream of the decode-stage hazard logic. Consumes its enables (en_F/en_D, 1 = advance, 0 = hold) and flushD.
//  Consumes the decode-stage npc_sel, compare result and forwarded JR target; presents instr_D/pc_D/pc4_D/valid_D to decode.
//  MIPS delayed branch: the delay-slot instruction always executes; taken branches never flush.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC of the first fetched instruction
//  IMEM_AW    10             ROM word-address width; imem_addr = pc[IMEM_AW+1:2]
//  CNT_W      32             width of the retired-fetch counter
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  en_F         in   1        1 = PC may advance; 0 = hold PC (load-use / branch stall)
//  en_D         in   1        1 = IF/ID loads; 0 = IF/ID holds
//  flushD       in   1        1 = IF/ID loads a bubble
//  npc_sel      in   3        000 seq, 001 BEQ, 010 J, 011 JR, 100 BNE (from decode)
//  cmp_eq_D     in   1        forwarded rs==rt compare result for the instruction in D
//  jr_target_D  in   32       forwarded rs value for JR
//  imem_addr    out  IMEM_AW  ROM address; ROM registers it; data valid next cycle
//  imem_rdata   in   32       ROM output word
//  instr_D      out  32       IF/ID instruction
//  pc_D         out  32       IF/ID PC
//  pc4_D        out  32       IF/ID PC+4
//  valid_D      out  1        IF/ID holds a real instruction
//  fetch_cnt    out  CNT_W    number of valid instructions loaded into IF/ID
// BEHAVIOUR
//  Reset (rst_n=0, async): pc_F=RESET_PC; instr_D=0; pc_D=0; pc4_D=0; valid_D=0; fetch_cnt=0; state=BOOT.
//  Reset asserted mid-operation: all of the above apply immediately, with no completion of the in-flight fetch.
//  FSM state BOOT: ROM output is not yet valid.
//   - imem_addr=pc_F. pc_F holds. IF/ID loads a bubble.
//   - Next state is RUN unconditionally; en_F and en_D are ignored in BOOT.
//  FSM state RUN: imem_rdata is the word at pc_F.
//   - pc_next = en_F ? target : pc_F. imem_addr = pc_next word address, so a held PC re-reads the same word and no skid buffer is needed.
//   - pc_F <= pc_next.
//  Next-PC target, all 32-bit arithmetic with wrap ignored:
//   - seq: pc_F+4.
//   - BEQ: taken if cmp_eq_D. Taken target = pc4_D + (sext(instr_D[15:0])<<2); not taken = pc_F+4.
//   - BNE: taken if !cmp_eq_D; same targets as BEQ.
//   - J: {pc4_D[31:28], instr_D[25:0], 2'b00}.
//   - JR: jr_target_D.
//   - Codes 101..111: treated as seq.
//   - npc_sel and the redirect are honoured only when valid_D=1; otherwise seq is used.
//  IF/ID register, evaluated in RUN in priority order:
//   - flushD=1: bubble (instr=0, valid=0, pc/pc4 = 0). flushD wins over en_D=0.
//   - else en_D=1: load {imem_rdata, pc_F, pc_F+4, valid=1}.
//   - else: hold all fields.
//  fetch_cnt increments by 1 on every non-bubble IF/ID load. It wraps modulo 2^CNT_W.
//  Latency: redirect computed in D at cycle t; the target instruction is in IF/ID at t+2, with the delay slot in D at t+1.
//  en_F=0 with en_D=1: legal. IF/ID reloads the same word with the same PC.
// STRUCTURE
//  Shared package (mips_defs): the npc_sel encodings NPC_SEQ/BEQ/J/JR/BNE and RESET_PC.
//  Optional sub-module: npc_calc, the combinational next-PC mux and adders. The rest stays flat.
// TESTING
//  1. Reset then free-run with ROM[i]=i:
//     - BOOT lasts 1 cycle with valid_D=0.
//     - Then pc_D = 0x3000, 0x3004, ... and instr_D=0,1,2,...
//  2. BEQ at 0x3008 with imm=4, cmp_eq_D=1:
//     - The delay slot at 0x300C reaches D.
//     - The next valid pc_D is 0x301C.
//     - Repeating with cmp_eq_D=0 gives 0x3010.
//  3. J with instr_index=0x0000C10 at pc 0x3010: the delay slot is 0x3014, then pc_D=0x3040.
//  4. JR with jr_target_D=0x3100: after the delay slot, pc_D=0x3100.
//  5. en_F=en_D=0 for 3 cycles mid-stream:
//     - imem_addr, pc_F and the IF/ID fields are frozen and fetch_cnt does not change.
//     - On release the sequence resumes with no skipped or duplicated PC.
//  6. Stall and async reset corner cases:
//     - flushD=1 together with en_D=0 gives valid_D=0 next cycle.
//     - rst_n pulsed low for half a cycle mid-run clears all outputs at once and restarts from BOOT at 0x3000.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the MIPS front end: next-PC select codes, boot PC
// and the fetch-stage state encoding.
package mips_defs;

   localparam logic [2:0] NPC_SEQ = 3'b000;
   localparam logic [2:0] NPC_BEQ = 3'b001;
   localparam logic [2:0] NPC_J   = 3'b010;
   localparam logic [2:0] NPC_JR  = 3'b011;
   localparam logic [2:0] NPC_BNE = 3'b100;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, conditional branch, jump and
// jump-register targets, driven by the instruction currently in decode.
module npc_calc
   import mips_defs::*;
(
   input  logic [2:0]  npc_sel,
   input  logic        valid_D,
   input  logic        cmp_eq_D,
   input  logic [31:0] pc_F,
   input  logic [31:0] pc4_D,
   input  logic [25:0] instr_idx_D,
   input  logic [31:0] jr_target_D,
   output logic [31:0] npc
);

   logic [31:0] w_seq;
   logic [31:0] w_br_target;

   assign w_seq       = pc_F + 32'd4;
   assign w_br_target = pc4_D + {{14{instr_idx_D[15]}}, instr_idx_D[15:0], 2'b00};

   // A bubble in decode must never steer fetch, whatever npc_sel says.
   always_comb begin
      npc = w_seq;
      if (valid_D) begin
         case (npc_sel)
            NPC_BEQ: npc = cmp_eq_D  ? w_br_target : w_seq;
            NPC_BNE: npc = !cmp_eq_D ? w_br_target : w_seq;
            NPC_J:   npc = {pc4_D[31:28], instr_idx_D, 2'b00};
            NPC_JR:  npc = jr_target_D;
            default: npc = w_seq;
         endcase
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: owns the PC, addresses a synchronous ROM and
// hands instructions to decode under the hazard unit's stall/flush control.
module fetch_stage
   import mips_defs::*;
#(
   parameter logic [31:0] RESET_PC = mips_defs::RESET_PC,
   parameter int          IMEM_AW  = 10,
   parameter int          CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en_F,
   input  logic               en_D,
   input  logic               flushD,
   input  logic [2:0]         npc_sel,
   input  logic               cmp_eq_D,
   input  logic [31:0]        jr_target_D,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        instr_D,
   output logic [31:0]        pc_D,
   output logic [31:0]        pc4_D,
   output logic               valid_D,
   output logic [CNT_W-1:0]   fetch_cnt
);

   fetch_state_t     r_state;
   logic [31:0]      r_pc_F;
   logic [31:0]      r_instr_D;
   logic [31:0]      r_pc_D;
   logic [31:0]      r_pc4_D;
   logic             r_valid_D;
   logic [CNT_W-1:0] r_fetch_cnt;

   logic [31:0]      w_target;
   logic [31:0]      w_pc_next;

   npc_calc u_npc_calc (
      .npc_sel     (npc_sel),
      .valid_D     (r_valid_D),
      .cmp_eq_D    (cmp_eq_D),
      .pc_F        (r_pc_F),
      .pc4_D       (r_pc4_D),
      .instr_idx_D (r_instr_D[25:0]),
      .jr_target_D (jr_target_D),
      .npc         (w_target)
   );

   // The ROM is addressed with the PC we are about to hold, so a stalled PC
   // keeps re-reading its own word and imem_rdata always matches r_pc_F.
   assign w_pc_next = (r_state == ST_RUN && en_F) ? w_target : r_pc_F;
   assign imem_addr = w_pc_next[IMEM_AW+1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_BOOT;
         r_pc_F      <= RESET_PC;
         r_instr_D   <= '0;
         r_pc_D      <= '0;
         r_pc4_D     <= '0;
         r_valid_D   <= 1'b0;
         r_fetch_cnt <= '0;
      end else begin
         case (r_state)
            ST_BOOT: begin
               r_state   <= ST_RUN;
               r_instr_D <= '0;
               r_pc_D    <= '0;
               r_pc4_D   <= '0;
               r_valid_D <= 1'b0;
            end
            default: begin
               r_pc_F <= w_pc_next;
               if (flushD) begin
                  r_instr_D <= '0;
                  r_pc_D    <= '0;
                  r_pc4_D   <= '0;
                  r_valid_D <= 1'b0;
               end else if (en_D) begin
                  r_instr_D   <= imem_rdata;
                  r_pc_D      <= r_pc_F;
                  r_pc4_D     <= r_pc_F + 32'd4;
                  r_valid_D   <= 1'b1;
                  r_fetch_cnt <= r_fetch_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign instr_D   = r_instr_D;
   assign pc_D      = r_pc_D;
   assign pc4_D     = r_pc4_D;
   assign valid_D   = r_valid_D;
   assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, branches, jumps, stalls, flush and
// asynchronous reset, against a bench-side synchronous ROM.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        en_F;
   logic        en_D;
   logic        flushD;
   logic [2:0]  npc_sel;
   logic        cmp_eq_D;
   logic [31:0] jr_target_D;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_D;
   logic [31:0] pc_D;
   logic [31:0] pc4_D;
   logic        valid_D;
   logic [31:0] fetch_cnt;

   logic [31:0] rom [0:1023];
   int          n_total;
   int          n_pass;
   int          n_fail;

   fetch_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_F        (en_F),
      .en_D        (en_D),
      .flushD      (flushD),
      .npc_sel     (npc_sel),
      .cmp_eq_D    (cmp_eq_D),
      .jr_target_D (jr_target_D),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr_D     (instr_D),
      .pc_D        (pc_D),
      .pc4_D       (pc4_D),
      .valid_D     (valid_D),
      .fetch_cnt   (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= rom[imem_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_d(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] cnt);
      $display("D %s: pc_D=%h instr_D=%h valid_D=%b fetch_cnt=%0d", tag, pc_D, instr_D, valid_D, fetch_cnt);
      check({tag, ".pc"},    pc_D,          pc);
      check({tag, ".pc4"},   pc4_D,         pc + 32'd4);
      check({tag, ".instr"}, instr_D,       ins);
      check({tag, ".valid"}, {31'd0, valid_D}, 32'd1);
      check({tag, ".cnt"},   fetch_cnt,     cnt);
   endtask

   initial begin
      n_total = 0; n_pass = 0; n_fail = 0;
      en_F = 1'b1; en_D = 1'b1; flushD = 1'b0;
      npc_sel = 3'b000; cmp_eq_D = 1'b0; jr_target_D = 32'd0;
      for (int i = 0; i < 1024; i++) rom[i] = i;
      rst_n = 1'b0;

      // 1. reset values, BOOT, then sequential free-run with ROM[i]=i
      #2;
      check("rst.valid", {31'd0, valid_D}, 32'd0);
      check("rst.instr", instr_D, 32'd0);
      check("rst.pc",    pc_D, 32'd0);
      check("rst.pc4",   pc4_D, 32'd0);
      check("rst.cnt",   fetch_cnt, 32'd0);
      check("rst.addr",  32'(imem_addr), 32'd0);
      do_reset();
      tick();
      check("boot.valid", {31'd0, valid_D}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check_d("seq", 32'h3000 + 32'(4 * k), 32'(k), 32'(k + 1));
      end

      // 2a. BEQ at 0x3008, imm=4, taken
      rom[2] = 32'h1000_0004;
      rom[4] = 32'h0800_0C10;
      do_reset();
      tick();
      tick(); tick(); tick();
      check_d("beq1.br", 32'h3008, 32'h1000_0004, 32'd3);
      npc_sel = 3'b001; cmp_eq_D = 1'b1;
      tick();
      npc_sel = 3'b000; cmp_eq_D = 1'b0;
      check_d("beq1.slot", 32'h300C, 32'd3, 32'd4);
      tick();
      check_d("beq1.tgt", 32'h301C, 32'd7, 32'd5);

      // 2b. same BEQ not taken, then 3. J, then 4. JR
      do_reset();
      tick();
      tick(); tick(); tick();
      npc_sel = 3'b001; cmp_eq_D = 1'b0;
      tick();
      npc_sel = 3'b000;
      check_d("beq0.slot", 32'h300C, 32'd3, 32'd4);
      tick();
      check_d("beq0.fall", 32'h3010, 32'h0800_0C10, 32'd5);
      npc_sel = 3'b010;
      tick();
      npc_sel = 3'b000;
      check_d("j.slot", 32'h3014, 32'd5, 32'd6);
      tick();
      check_d("j.tgt", 32'h3040, 32'd16, 32'd7);
      npc_sel = 3'b011; jr_target_D = 32'h3100;
      tick();
      npc_sel = 3'b000; jr_target_D = 32'd0;
      check_d("jr.slot", 32'h3044, 32'd17, 32'd8);
      tick();
      check_d("jr.tgt", 32'h3100, 32'd64, 32'd9);

      // 5. three-cycle full stall
      en_F = 1'b0; en_D = 1'b0;
      #1;
      check("stall.addr0", 32'(imem_addr), 32'h41);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall.addr", 32'(imem_addr), 32'h41);
         check_d("stall", 32'h3100, 32'd64, 32'd9);
      end
      en_F = 1'b1; en_D = 1'b1;
      tick();
      check_d("rel1", 32'h3104, 32'd65, 32'd10);
      tick();
      check_d("rel2", 32'h3108, 32'd66, 32'd11);

      // 6a. flushD wins over en_D=0
      flushD = 1'b1; en_D = 1'b0;
      tick();
      $display("D flush: pc_D=%h instr_D=%h valid_D=%b fetch_cnt=%0d", pc_D, instr_D, valid_D, fetch_cnt);
      check("flush.valid", {31'd0, valid_D}, 32'd0);
      check("flush.instr", instr_D, 32'd0);
      check("flush.pc",    pc_D, 32'd0);
      check("flush.cnt",   fetch_cnt, 32'd11);
      flushD = 1'b0; en_D = 1'b1;
      tick();
      check_d("post_flush", 32'h3110, 32'd68, 32'd12);

      // 6b. half-cycle asynchronous reset pulse mid-run
      rst_n = 1'b0;
      #1;
      $display("D areset: pc_D=%h instr_D=%h valid_D=%b fetch_cnt=%0d", pc_D, instr_D, valid_D, fetch_cnt);
      check("ar.valid", {31'd0, valid_D}, 32'd0);
      check("ar.instr", instr_D, 32'd0);
      check("ar.pc",    pc_D, 32'd0);
      check("ar.pc4",   pc4_D, 32'd0);
      check("ar.cnt",   fetch_cnt, 32'd0);
      check("ar.addr",  32'(imem_addr), 32'd0);
      #4;
      rst_n = 1'b1;
      tick();
      check("ar.boot", {31'd0, valid_D}, 32'd0);
      tick();
      check_d("ar.first", 32'h3000, 32'd0, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
